// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg : 640x480@60 timing defaults, 12-bit colour layout, width helper     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vga_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;

   localparam int COLOR_W = 12;
   localparam int CH_W    = 4;
   localparam int R_OFS   = 8;
   localparam int G_OFS   = 4;
   localparam int B_OFS   = 0;

   typedef logic [COLOR_W-1:0] color_t;

   localparam color_t COLOR_BLACK = 12'h000;
   localparam color_t COLOR_WHITE = 12'hFFF;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing : h/v raster counters, active-low sync decode and frame strobes  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FRONT   = VGA_H_FRONT,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FRONT   = VGA_V_FRONT,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK
) (
   input  logic clk,
   input  logic rst,
   output logic h_active,
   output logic v_active,
   output logic hs_n,
   output logic vs_n,
   output logic line_end,
   output logic frame_end,
   output logic frame_origin
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = bits_for(H_TOTAL);
   localparam int VW      = bits_for(V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
   localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
   localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
   localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
   localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [HW-1:0] h_count;
   logic [VW-1:0] v_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         h_count <= '0;
         v_count <= '0;
      end else if (line_end) begin
         h_count <= '0;
         v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end else begin
         h_count <= h_count + 1'b1;
      end
   end

   assign line_end     = (h_count == H_LAST);
   assign frame_end    = line_end && (v_count == V_LAST);
   assign frame_origin = (h_count == '0) && (v_count == '0);
   assign h_active     = (h_count < H_VIS);
   assign v_active     = (v_count < V_VIS);
   assign hs_n         = !((h_count >= HS_START) && (h_count < HS_END));
   assign vs_n         = !((v_count >= VS_START) && (v_count < VS_END));

endmodule
`default_nettype wire

// File: rtl/vga_tile_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_tile_display : tiled colour VGA source with a double-buffered palette.  |
// | Optional VGA_GRID_LINES_EN draws white tile borders. Revision: 1.0          |
// +----------------------------------------------------------------------------+
module vga_tile_display
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FRONT   = VGA_H_FRONT,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FRONT   = VGA_V_FRONT,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK,
   parameter int TILES_X   = 4,
   parameter int TILES_Y   = 4
) (
   input  logic                                 clk_25MHz,
   input  logic                                 rst,
   input  logic                                 wr_en,
   input  logic [$clog2(TILES_X*TILES_Y)-1:0]   wr_addr,
   input  logic [11:0]                          wr_data,
   output logic [3:0]                           vga_r,
   output logic [3:0]                           vga_g,
   output logic [3:0]                           vga_b,
   output logic                                 vga_hs,
   output logic                                 vga_vs,
   output logic                                 frame_start
);

   localparam int N_TILES = TILES_X * TILES_Y;
   localparam int AW      = $clog2(N_TILES);
   localparam int TILE_W  = H_VISIBLE / TILES_X;
   localparam int TILE_H  = V_VISIBLE / TILES_Y;
   localparam int PW      = bits_for(TILE_W);
   localparam int LW      = bits_for(TILE_H);
   localparam int CW      = bits_for(TILES_X);
   localparam int RW      = bits_for(TILES_Y);

   localparam logic [PW-1:0] PX_LAST   = PW'(TILE_W - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(TILE_H - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(TILES_X - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(TILES_Y - 1);
   localparam logic [AW:0]   N_LIMIT   = (AW+1)'(N_TILES);

   logic h_active, v_active, hs_n, vs_n, line_end, frame_end, frame_origin;

   vga_timing #(
      .H_VISIBLE (H_VISIBLE),
      .H_FRONT   (H_FRONT),
      .H_SYNC    (H_SYNC),
      .H_BACK    (H_BACK),
      .V_VISIBLE (V_VISIBLE),
      .V_FRONT   (V_FRONT),
      .V_SYNC    (V_SYNC),
      .V_BACK    (V_BACK)
   ) u_timing (
      .clk          (clk_25MHz),
      .rst          (rst),
      .h_active     (h_active),
      .v_active     (v_active),
      .hs_n         (hs_n),
      .vs_n         (vs_n),
      .line_end     (line_end),
      .frame_end    (frame_end),
      .frame_origin (frame_origin)
   );

   // Tile position tracked incrementally so no divider sits in the pixel path.
   logic [PW-1:0] px_in_tile;
   logic [CW-1:0] tile_col;
   logic [LW-1:0] line_in_tile;
   logic [RW-1:0] tile_row;

   always_ff @(posedge clk_25MHz) begin
      if (rst || line_end) begin
         px_in_tile <= '0;
         tile_col   <= '0;
      end else if (h_active) begin
         if (px_in_tile == PX_LAST) begin
            px_in_tile <= '0;
            tile_col   <= (tile_col == COL_LAST) ? '0 : tile_col + 1'b1;
         end else begin
            px_in_tile <= px_in_tile + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_25MHz) begin
      if (rst || frame_end) begin
         line_in_tile <= '0;
         tile_row     <= '0;
      end else if (line_end && v_active) begin
         if (line_in_tile == LINE_LAST) begin
            line_in_tile <= '0;
            tile_row     <= (tile_row == ROW_LAST) ? '0 : tile_row + 1'b1;
         end else begin
            line_in_tile <= line_in_tile + 1'b1;
         end
      end
   end

   logic [AW-1:0] tile_idx;
   assign tile_idx = AW'(tile_row) * AW'(TILES_X) + AW'(tile_col);

   // The commit copies the pre-write shadow, so a same-cycle write waits a frame.
   color_t shadow_tbl [N_TILES];
   color_t active_tbl [N_TILES];

   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         shadow_tbl <= '{default: COLOR_BLACK};
         active_tbl <= '{default: COLOR_BLACK};
      end else begin
         if (wr_en && ({1'b0, wr_addr} < N_LIMIT)) begin
            shadow_tbl[wr_addr] <= wr_data;
         end
         if (frame_end) begin
            active_tbl <= shadow_tbl;
         end
      end
   end

   color_t pixel_color;

   always_comb begin
      pixel_color = active_tbl[tile_idx];
`ifdef VGA_GRID_LINES_EN
      if ((px_in_tile == '0) || (line_in_tile == '0)) begin
         pixel_color = COLOR_WHITE;
      end
`endif
   end

   color_t rgb;

   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         rgb         <= COLOR_BLACK;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         rgb         <= (h_active && v_active) ? pixel_color : COLOR_BLACK;
         vga_hs      <= hs_n;
         vga_vs      <= vs_n;
         frame_start <= frame_origin;
      end
   end

   assign vga_r = rgb[R_OFS +: CH_W];
   assign vga_g = rgb[G_OFS +: CH_W];
   assign vga_b = rgb[B_OFS +: CH_W];

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_tile_display : random palette traffic against a raster-level model   |
// | on a reduced 3x3-tile timing. Revision: 1.0                                 |
// +----------------------------------------------------------------------------+
module tb_vga_tile_display;

   localparam int HV = 18, HF = 2, HSW = 3, HB = 3;
   localparam int VV = 12, VF = 1, VSW = 2, VB = 2;
   localparam int TX = 3,  TY = 3;
   localparam int HT = HV + HF + HSW + HB;
   localparam int VT = VV + VF + VSW + VB;
   localparam int FT = HT * VT;
   localparam int NT = TX * TY;
   localparam int TW = HV / TX;
   localparam int TH = VV / TY;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, frame_start;

   always #20 clk = ~clk;

   vga_tile_display #(
      .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
      .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
      .TILES_X   (TX), .TILES_Y (TY)
   ) dut (
      .clk_25MHz   (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .frame_start (frame_start)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference: raster position p counts pixels since frame origin.
   int          p = 0;
   logic [11:0] sh  [NT];
   logic [11:0] act [NT];
   logic        seen_fs = 1'b0;
   int          since = 0, hs_low = 0, vs_low = 0;

   function automatic logic [14:0] predict(input int pos);
      int h, v, t;
      logic [11:0] c;
      logic hs_e, vs_e;
      h = pos % HT;
      v = pos / HT;
      c = 12'h000;
      if (h < HV && v < VV) begin
         t = (v / TH) * TX + (h / TW);
         c = act[t];
`ifdef VGA_GRID_LINES_EN
         if ((h % TW) == 0 || (v % TH) == 0) c = 12'hFFF;
`endif
      end
      hs_e = !(h >= HV + HF && h < HV + HF + HSW);
      vs_e = !(v >= VV + VF && v < VV + VF + VSW);
      return {c, hs_e, vs_e, (pos == 0)};
   endfunction

   task automatic cycle(input logic r, input logic we, input logic [3:0] a, input logic [11:0] d);
      logic [14:0] exp_out;
      rst = r; wr_en = we; wr_addr = a; wr_data = d;
      @(posedge clk);
      if (r) begin
         exp_out = {12'h000, 1'b1, 1'b1, 1'b0};
         p = 0;
         foreach (sh[i]) begin
            sh[i]  = 12'h000;
            act[i] = 12'h000;
         end
      end else begin
         exp_out = predict(p);
         if (p == FT - 1) act = sh;
         if (we && int'(a) < NT) sh[a] = d;
         p = (p + 1) % FT;
      end
      @(negedge clk);
      check_val("pixel{rgb,hs,vs,fs}", {vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start}, exp_out);
      if (r) begin
         seen_fs = 1'b0;
      end else begin
         if (frame_start) begin
            if (seen_fs) begin
               check_val("frame_period", since, FT);
               check_val("hs_low_per_frame", hs_low, VT * HSW);
               check_val("vs_low_per_frame", vs_low, VSW * HT);
            end
            seen_fs = 1'b1;
            since = 0; hs_low = 0; vs_low = 0;
         end
         since++;
         if (!vga_hs) hs_low++;
         if (!vga_vs) vs_low++;
      end
   endtask

   task automatic run_random(input int n, input int pct, input int amax);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 99) < pct)
            cycle(1'b0, 1'b1, 4'($urandom_range(0, amax)), 12'($urandom));
         else
            cycle(1'b0, 1'b0, 4'h0, 12'h000);
      end
   endtask

   task automatic idle_until(input int pos);
      for (int i = 0; i < FT && p != pos; i++) cycle(1'b0, 1'b0, 4'h0, 12'h000);
   endtask

   initial begin
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'h0, 12'h000);

      // Fill all tiles, then random traffic including out-of-range addresses.
      for (int i = 0; i < NT; i++) cycle(1'b0, 1'b1, 4'(i), 12'($urandom));
      run_random(3 * FT, 25, 15);

      // Mid-frame write to the centre tile: visible only after the next commit.
      idle_until(FT / 2);
      cycle(1'b0, 1'b1, 4'd4, 12'hF00);
      idle_until(FT - 1);
      cycle(1'b0, 1'b1, 4'd0, 12'h000);

      // Collision: write in the commit cycle lands one frame later.
      idle_until(FT - 1);
      cycle(1'b0, 1'b1, 4'd0, 12'h0F0);
      run_random(2 * FT, 0, 15);

      // Only out-of-range writes for a whole frame.
      for (int i = 0; i < FT; i++) cycle(1'b0, 1'b1, 4'($urandom_range(NT, 15)), 12'($urandom));
      run_random(FT, 0, 15);

      // Reset mid-frame discards pending shadow writes and aborts the frame.
      run_random(FT / 3, 40, 8);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h0, 12'h000);

      for (int i = 0; i < NT; i++) cycle(1'b0, 1'b1, 4'(i), 12'h00F);
      run_random(3 * FT, 10, 15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_tile_display.md
VGA_TILE_DISPLAY -- requirements
Module: vga_tile_display

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, H_SYNC, H_BACK, defaults 16, 96, 48: horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480: visible lines per frame.
REQ-004 SHALL have parameter V_FRONT, V_SYNC, V_BACK, defaults 10, 2, 33: vertical porch and sync widths in lines.
REQ-005 SHALL have parameter TILES_X, TILES_Y, defaults 4, 4: tile grid dimensions. H_VISIBLE and V_VISIBLE divide exactly.
REQ-006 SHALL have ports: clk_25MHz in 1 pixel clock; rst in 1 synchronous active-high reset, the only reset. This is the only clock.
REQ-007 SHALL have ports: wr_en in 1 palette write strobe; wr_addr in AW, where AW=$clog2(TILES_X*TILES_Y), tile index row-major; wr_data in 12 colour {R[3:0],G[3:0],B[3:0]}.
REQ-008 SHALL have ports: vga_r, vga_g, vga_b out 4 each; vga_hs, vga_vs out 1, active-low; frame_start out 1, a one-cycle pulse.

Function
REQ-009 Counters: h_count wraps at H_TOTAL-1, where H_TOTAL is the sum of the H_* parameters. v_count advances on each h wrap and wraps at V_TOTAL-1.
REQ-010 Tile index: derived from sub-tile counters that reset at line and frame start, with no divider. tile_col increments when px_in_tile==TILE_W-1. tile_row increments when line_in_tile==TILE_H-1 at the h wrap.
REQ-011 Palette: two register tables of TILES_X*TILES_Y x 12 bits. wr_* writes only the shadow table.
REQ-012 A write takes effect in the shadow table the cycle after wr_en is sampled.
REQ-013 A write with wr_addr >= TILES_X*TILES_Y SHALL be ignored.
REQ-014 Commit: on the last pixel of a frame (h_count==H_TOTAL-1 && v_count==V_TOTAL-1), the active table copies the whole shadow table in one cycle.
REQ-015 If a write and a commit occur in the same cycle, the write SHALL NOT be in that commit. It lands in the shadow table and is committed at the next frame end.
REQ-016 Displayed colour comes from the active table only, so there is no tearing within a frame.
REQ-017 Pipeline: vga_r/g/b, vga_hs and vga_vs are all registered with exactly 1 cycle latency from the counter state, and stay mutually aligned.
REQ-018 hs is low for h_count in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC). vs is low for v_count in the equivalent vertical range.
REQ-019 Outside the visible area, RGB SHALL be 0.
REQ-020 frame_start SHALL be high for one cycle, coincident with the registered output of pixel (0,0).

Reset
REQ-021 While rst is high, h_count, v_count, tile counters, both palette tables, vga_r/g/b and frame_start are 0, and vga_hs=vga_vs=1.
REQ-022 In the first cycle after rst deasserts, counters are at (0,0), and the first output pixel appears 1 cycle later.
REQ-023 rst asserted mid-frame aborts the frame with no commit. Pending shadow writes are lost.

Configuration
REQ-024 With VGA_GRID_LINES_EN defined: the first pixel column and first line of every tile output 12'hFFF (white) instead of the tile colour, still within the visible area only. This adds no latency.
REQ-025 Without VGA_GRID_LINES_EN, every visible pixel shows its tile colour, and no grid logic is synthesised.

Structure
REQ-026 Package vga_pkg SHALL hold the default 640x480@60 timing constants and the 12-bit colour field widths/offsets.
REQ-027 Sub-module vga_timing SHALL contain h/v counters, sync decode, visible flag and frame-end strobe. vga_tile_display instantiates it once.
REQ-028 Palette, tile counters and output register SHALL be in vga_tile_display.

Verification
REQ-029 Reset: hold rst 5 cycles. All RGB=0, hs=vs=1, frame_start=0. After release, frame_start pulses exactly 1 cycle after the first counter (0,0).
REQ-030 Timing: run 2 frames at defaults. hs low 96 cycles per 800-cycle line. vs low 2 lines per 525-line frame. frame_start period is 420000 cycles.
REQ-031 Double buffer: mid-frame, write addr 5 = 12'hF00. Tile (1,1) stays 0 for the rest of that frame. From the next frame, output pixels at x 160..319 and y 120..239 are R=F, G=0, B=0.
REQ-032 Collision: write addr 0 = 12'h0F0 in the commit cycle. The next frame shows tile 0 black. The frame after shows it green.
REQ-033 Out-of-range: with TILES_X=3, TILES_Y=3, a write to addr 9..15 changes no visible pixel.
REQ-034 Grid (VGA_GRID_LINES_EN): with all tiles 12'h00F, x=0,160,320,480 and y=0,120,240,360 are FFF, other visible pixels are 00F, and the blanking region is 0.
